ifetch_buffer: RTL and testbench

//  Fetch stage upstream of the 5-stage ARM datapath: drives PC to instruction memory over req/ack, queues

---
 rtl/arm_pipe_pkg.sv | 19 +
 rtl/ifb_fifo.sv | 58 +++++
 rtl/ifetch_buffer.sv | 144 ++++++++++++++
 tb/tb_ifetch_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared fetch-side definitions for the ARM pipeline: NOP encoding, the
// instruction-buffer state encoding and the queued {pc, instr} entry.
package arm_pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'hE1A0_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFB_IDLE    = 2'd0,
    IFB_REQ     = 2'd1,
    IFB_DISCARD = 2'd2
  } ifb_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifb_entry_t;

endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO of {pc, instr} entries with push/pop/flush and occupancy.
// Flush has priority over push and pop on the same edge.
module ifb_fifo
  import arm_pipe_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  ifb_entry_t    i_wdata,
  output ifb_entry_t    o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  ifb_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A push into a full queue is only accepted when the head leaves the same edge.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch stage: issues imem requests, queues returned words with their PC and
// presents the head to decode. IFB_BYPASS_EN adds a same-cycle empty-queue bypass.
//
// state   | meaning
// IDLE    | no request outstanding; start one when the queue has room
// REQ     | request up at ImemAddr; ack data is pushed (or bypassed)
// DISCARD | redirected while a request was outstanding; drop its ack
module ifetch_buffer
  import arm_pipe_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRData,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Advance,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        InstrValid,
  output logic        FetchStall
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifb_state_e    r_state;
  ifb_state_e    w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   w_req_addr_nxt;
  logic [31:0]   w_redirect_pc;
  logic          w_ack_keep;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_post;
  logic          w_valid;
  ifb_entry_t    w_head;
  ifb_entry_t    w_wdata;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;

  assign w_redirect_pc = RedirectPC & ~32'd3;
  assign w_ack_keep    = (r_state == IFB_REQ) && ImemAck && !Redirect;

`ifdef IFB_BYPASS_EN
  assign w_bypass = w_ack_keep && w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word that decode takes immediately never occupies a slot.
  assign w_push       = w_ack_keep && !(w_bypass && Advance);
  assign w_pop        = !w_fifo_empty && Advance && !Redirect;
  assign w_count_post = w_fifo_count + CW'(w_push) - CW'(w_pop);
  assign w_wdata      = '{pc: r_req_addr, instr: ImemRData};

  ifb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (Redirect),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IFB_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_addr_nxt = r_req_addr;
    unique case (r_state)
      IFB_IDLE: begin
        if (Redirect) w_fetch_pc_nxt = w_redirect_pc;
        else if (!w_fifo_full) w_state_nxt = IFB_REQ;
        w_req_addr_nxt = w_fetch_pc_nxt;
      end
      IFB_REQ: begin
        if (ImemAck && Redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_req_addr_nxt = w_redirect_pc;
        end else if (ImemAck) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_req_addr_nxt = r_fetch_pc + 32'd4;
          w_state_nxt    = (w_count_post < CW'(DEPTH)) ? IFB_REQ : IFB_IDLE;
        end else if (Redirect) begin
          // imem still owns the old address; keep it stable until its ack
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = IFB_DISCARD;
        end
      end
      IFB_DISCARD: begin
        if (Redirect) w_fetch_pc_nxt = w_redirect_pc;
        if (ImemAck) begin
          w_state_nxt    = IFB_REQ;
          w_req_addr_nxt = w_fetch_pc_nxt;
        end
      end
      default: w_state_nxt = IFB_IDLE;
    endcase
  end

  assign ImemReq  = (r_state != IFB_IDLE);
  assign ImemAddr = r_req_addr;

  always_comb begin
    w_valid    = !w_fifo_empty || w_bypass;
    InstrValid = w_valid;
    InstrF     = NOP_INSTR;
    PCF        = '0;
    if (w_bypass) begin
      InstrF = ImemRData;
      PCF    = r_req_addr;
    end else if (w_valid) begin
      InstrF = w_head.instr;
      PCF    = w_head.pc;
    end
  end

  assign FetchStall = !w_valid;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: an imem model with programmable ack
// latency and a scoreboard of expected {pc, instr} words popped as decode consumes.
module tb_ifetch_buffer;
  import arm_pipe_pkg::*;

  localparam int DEPTH = 4;
`ifdef IFB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRData;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        Advance = 1'b0;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        InstrValid;
  logic        FetchStall;

  int n_cmp = 0;
  int n_mis = 0;
  int lat = 1;
  int wait_cnt = 0;
  logic [31:0] exp_addr;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h20) return 32'hE3A0_1005;
    return 32'hE280_0000 ^ a;
  endfunction

  assign ImemAck   = ImemReq && (wait_cnt >= lat - 1);
  assign ImemRData = mem_word(ImemAddr);

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (ImemReq && !ImemAck) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemAck    (ImemAck),
    .ImemRData  (ImemRData),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Advance    (Advance),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .InstrValid (InstrValid),
    .FetchStall (FetchStall)
  );

  task automatic reset_dut();
    reset = 1'b0; Redirect = 1'b0; RedirectPC = '0; Advance = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic push_stream(input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({pc0 + 32'(4 * i), mem_word(pc0 + 32'(4 * i))});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ImemReq !== 1'b0) begin n_mis++; $display("FAIL rst_req: got %b, expected 0", ImemReq); end
    n_cmp++; if (ImemAddr !== 32'h0) begin n_mis++; $display("FAIL rst_addr: got %h, expected 0", ImemAddr); end
    n_cmp++; if (InstrValid !== 1'b0 || FetchStall !== 1'b1) begin n_mis++; $display("FAIL rst_valid: got v=%b s=%b, expected v=0 s=1", InstrValid, FetchStall); end
    n_cmp++; if (InstrF !== NOP_INSTR || PCF !== 32'h0) begin n_mis++; $display("FAIL rst_instr: got %h/%h, expected %h/0", InstrF, PCF, NOP_INSTR); end
  endtask

  task automatic test_stream();
    logic [63:0] e;
    bit seen = 1'b0;
    reset_dut(); lat = 1; Advance = 1'b1; exp_addr = 32'h0;
    push_stream(32'h0, 8);
    @(negedge clk);
    n_cmp++; if (ImemReq !== 1'b0) begin n_mis++; $display("FAIL stream_idle: got req=%b, expected 0", ImemReq); end
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        n_cmp++; if (InstrValid !== BYP) begin n_mis++; $display("FAIL stream_first_valid: got %b, expected %b", InstrValid, BYP); end
      end
      if (seen) begin
        n_cmp++; if (ImemReq !== 1'b1) begin n_mis++; $display("FAIL stream_b2b: got req=%b, expected 1", ImemReq); end
      end
      seen = seen | ImemReq;
      if (InstrValid && Advance && !Redirect) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_mis++; $display("FAIL stream_extra: got pc=%h, expected none", PCF); end
        else begin
          e = exp_q.pop_front();
          if ({PCF, InstrF} !== e) begin n_mis++; $display("FAIL stream_word: got %h/%h, expected %h/%h", PCF, InstrF, e[63:32], e[31:0]); end
        end
      end
      if (ImemReq && ImemAck) begin
        n_cmp++; if (ImemAddr !== exp_addr) begin n_mis++; $display("FAIL stream_addr: got %h, expected %h", ImemAddr, exp_addr); end
        exp_addr += 32'd4;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL stream_timeout: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_full();
    logic [63:0] e;
    int acks = 0;
    reset_dut(); lat = 1; Advance = 1'b0; exp_addr = 32'h0;
    repeat (10) begin
      @(negedge clk);
      if (ImemReq && ImemAck) begin
        acks++;
        n_cmp++; if (ImemAddr !== exp_addr) begin n_mis++; $display("FAIL full_addr: got %h, expected %h", ImemAddr, exp_addr); end
        exp_addr += 32'd4;
      end
    end
    n_cmp++; if (acks != DEPTH) begin n_mis++; $display("FAIL full_acks: got %0d, expected %0d", acks, DEPTH); end
    n_cmp++; if (ImemReq !== 1'b0) begin n_mis++; $display("FAIL full_req: got %b, expected 0", ImemReq); end
    n_cmp++; if (InstrValid !== 1'b1 || PCF !== 32'h0) begin n_mis++; $display("FAIL full_head: got v=%b pc=%h, expected 1/0", InstrValid, PCF); end
    push_stream(32'h0, 6);
    @(posedge clk); #1 Advance = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (InstrValid && Advance && !Redirect) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_mis++; $display("FAIL full_extra: got pc=%h, expected none", PCF); end
        else begin
          e = exp_q.pop_front();
          if ({PCF, InstrF} !== e) begin n_mis++; $display("FAIL full_word: got %h/%h, expected %h/%h", PCF, InstrF, e[63:32], e[31:0]); end
        end
      end
      if (ImemReq && ImemAck) begin
        n_cmp++; if (ImemAddr !== exp_addr) begin n_mis++; $display("FAIL full_resume_addr: got %h, expected %h", ImemAddr, exp_addr); end
        exp_addr += 32'd4;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL full_timeout: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect_wait();
    logic [63:0] e;
    reset_dut(); lat = 3; Advance = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0 || ImemAck !== 1'b0) begin n_mis++; $display("FAIL rw_wait1: got req=%b addr=%h ack=%b, expected 1/0/0", ImemReq, ImemAddr, ImemAck); end
    @(posedge clk); #1 Redirect = 1'b1; RedirectPC = 32'h100;
    @(negedge clk);
    n_cmp++; if (ImemAddr !== 32'h0 || ImemAck !== 1'b0 || InstrValid !== 1'b0) begin n_mis++; $display("FAIL rw_wait2: got addr=%h ack=%b v=%b, expected 0/0/0", ImemAddr, ImemAck, InstrValid); end
    @(posedge clk); #1 Redirect = 1'b0;
    @(negedge clk);
    n_cmp++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0 || ImemAck !== 1'b1 || InstrValid !== 1'b0) begin n_mis++; $display("FAIL rw_hold: got req=%b addr=%h ack=%b v=%b, expected 1/0/1/0", ImemReq, ImemAddr, ImemAck, InstrValid); end
    exp_addr = 32'h100;
    push_stream(32'h100, 2);
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (InstrValid && Advance && !Redirect) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_mis++; $display("FAIL rw_extra: got pc=%h, expected none", PCF); end
        else begin
          e = exp_q.pop_front();
          if ({PCF, InstrF} !== e) begin n_mis++; $display("FAIL rw_word: got %h/%h, expected %h/%h", PCF, InstrF, e[63:32], e[31:0]); end
        end
      end
      if (ImemReq && ImemAck) begin
        n_cmp++; if (ImemAddr !== exp_addr) begin n_mis++; $display("FAIL rw_addr: got %h, expected %h", ImemAddr, exp_addr); end
        exp_addr += 32'd4;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL rw_timeout: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect_ack();
    logic [63:0] e;
    reset_dut(); lat = 1; Advance = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 Redirect = 1'b1; RedirectPC = 32'h203; Advance = 1'b1;
    @(negedge clk);
    n_cmp++; if (InstrValid !== 1'b1 || PCF !== 32'h0 || ImemAck !== 1'b1 || ImemAddr !== 32'h8) begin n_mis++; $display("FAIL ra_pre: got v=%b pc=%h ack=%b addr=%h, expected 1/0/1/8", InstrValid, PCF, ImemAck, ImemAddr); end
    @(posedge clk); #1 Redirect = 1'b0; Advance = 1'b0;
    @(negedge clk);
    n_cmp++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h200) begin n_mis++; $display("FAIL ra_addr: got req=%b addr=%h, expected 1/200", ImemReq, ImemAddr); end
    n_cmp++; if (InstrValid !== BYP || PCF !== (BYP ? 32'h200 : 32'h0)) begin n_mis++; $display("FAIL ra_flush: got v=%b pc=%h, expected v=%b", InstrValid, PCF, BYP); end
    exp_addr = 32'h204;
    push_stream(32'h200, 3);
    @(posedge clk); #1 Advance = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (InstrValid && Advance && !Redirect) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_mis++; $display("FAIL ra_extra: got pc=%h, expected none", PCF); end
        else begin
          e = exp_q.pop_front();
          if ({PCF, InstrF} !== e) begin n_mis++; $display("FAIL ra_word: got %h/%h, expected %h/%h", PCF, InstrF, e[63:32], e[31:0]); end
        end
      end
      if (ImemReq && ImemAck) begin
        n_cmp++; if (ImemAddr !== exp_addr) begin n_mis++; $display("FAIL ra_next_addr: got %h, expected %h", ImemAddr, exp_addr); end
        exp_addr += 32'd4;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL ra_timeout: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_empty_reset();
    logic [63:0] e;
    reset_dut(); lat = 5; Advance = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (ImemReq !== 1'b1 || InstrValid !== 1'b0 || FetchStall !== 1'b1) begin n_mis++; $display("FAIL er_empty: got req=%b v=%b s=%b, expected 1/0/1", ImemReq, InstrValid, FetchStall); end
    n_cmp++; if (InstrF !== 32'hE1A0_0000 || PCF !== 32'h0) begin n_mis++; $display("FAIL er_nop: got %h/%h, expected e1a00000/0", InstrF, PCF); end
    @(posedge clk); #1 reset = 1'b0;
    #1;
    n_cmp++; if (ImemReq !== 1'b0) begin n_mis++; $display("FAIL er_async: got req=%b, expected 0", ImemReq); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; lat = 1; exp_addr = 32'h0;
    push_stream(32'h0, 2);
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (InstrValid && Advance && !Redirect) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_mis++; $display("FAIL er_extra: got pc=%h, expected none", PCF); end
        else begin
          e = exp_q.pop_front();
          if ({PCF, InstrF} !== e) begin n_mis++; $display("FAIL er_word: got %h/%h, expected %h/%h", PCF, InstrF, e[63:32], e[31:0]); end
        end
      end
      if (ImemReq && ImemAck) begin
        n_cmp++; if (ImemAddr !== exp_addr) begin n_mis++; $display("FAIL er_restart_addr: got %h, expected %h", ImemAddr, exp_addr); end
        exp_addr += 32'd4;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL er_timeout: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_bypass();
    reset_dut(); lat = 1;
    Redirect = 1'b1; RedirectPC = 32'h20; Advance = 1'b1;
    @(posedge clk); #1 Redirect = 1'b0;
    @(negedge clk);
    n_cmp++; if (ImemReq !== 1'b0) begin n_mis++; $display("FAIL bp_idle: got req=%b, expected 0", ImemReq); end
    @(negedge clk);
    n_cmp++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h20 || ImemAck !== 1'b1) begin n_mis++; $display("FAIL bp_req: got req=%b addr=%h ack=%b, expected 1/20/1", ImemReq, ImemAddr, ImemAck); end
    if (BYP) begin
      n_cmp++; if (InstrValid !== 1'b1 || InstrF !== 32'hE3A0_1005 || PCF !== 32'h20) begin n_mis++; $display("FAIL bp_same: got v=%b %h/%h, expected 1 e3a01005/20", InstrValid, InstrF, PCF); end
    end else begin
      n_cmp++; if (InstrValid !== 1'b0) begin n_mis++; $display("FAIL bp_same: got v=%b, expected 0", InstrValid); end
    end
    @(negedge clk);
    if (BYP) begin
      n_cmp++; if (InstrValid !== 1'b1 || PCF !== 32'h24) begin n_mis++; $display("FAIL bp_nopush: got v=%b pc=%h, expected 1/24", InstrValid, PCF); end
    end else begin
      n_cmp++; if (InstrValid !== 1'b1 || InstrF !== 32'hE3A0_1005 || PCF !== 32'h20) begin n_mis++; $display("FAIL bp_next: got v=%b %h/%h, expected 1 e3a01005/20", InstrValid, InstrF, PCF); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_ack();
    test_empty_reset();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
